// File: rtl/div_if.sv
// Handshake and result bundle between the execute stage and the
// multi-cycle RV32M divider.
interface div_if;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [4:0]  reg_waddr_i;
   logic        flush_i;
   logic [31:0] result_o;
   logic        ready_o;
   logic [4:0]  reg_waddr_o;
   logic        div_busy_o;

   // Execute stage side: issues requests and consumes results
   modport master (
      output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
      input  result_o, ready_o, reg_waddr_o, div_busy_o
   );

   // Divider side
   modport slave (
      input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
      output result_o, ready_o, reg_waddr_o, div_busy_o
   );
endinterface

// File: rtl/div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU).
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle over 32 CALC cycles, with the sign fix applied when the result
// register is loaded. Divide by zero short-circuits straight to END.
module div (
   input logic  clk,
   input logic  rst,
   div_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, END} state_t;

   state_t      state;
   logic [4:0]  count;
   logic        op_rem;
   logic        neg_q;
   logic        neg_r;
   logic [31:0] dvd;
   logic [31:0] dsr;
   logic [31:0] rem;
   logic [31:0] quo;
   logic [31:0] result_q;
   logic        ready_q;
   logic [4:0]  waddr_q;

   logic        start_ok;
   logic        in_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] shifted;
   logic [33:0] diff;
   logic        ge;
   logic [31:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] final_val;

   assign bus.result_o    = result_q;
   assign bus.ready_o     = ready_q;
   assign bus.reg_waddr_o = waddr_q;
   assign bus.div_busy_o  = (state != IDLE);

   // Request decode and operand magnitudes; flush beats a simultaneous start
   always_comb begin
      start_ok  = bus.start_i & bus.op_i[2] & ~bus.flush_i;
      in_signed = ~bus.op_i[0];
      a_neg     = in_signed & bus.dividend_i[31];
      b_neg     = in_signed & bus.divisor_i[31];
      a_mag     = a_neg ? (32'd0 - bus.dividend_i) : bus.dividend_i;
      b_mag     = b_neg ? (32'd0 - bus.divisor_i) : bus.divisor_i;
   end

   // One restoring step; the trial remainder needs 33 bits because the
   // shifted value can reach twice the divisor magnitude minus one
   always_comb begin
      shifted   = {rem, dvd[31]};
      diff      = {1'b0, shifted} - {2'b00, dsr};
      ge        = ~diff[33];
      rem_next  = ge ? diff[31:0] : shifted[31:0];
      quo_next  = {quo[30:0], ge};
      if (op_rem) begin
         final_val = neg_r ? (32'd0 - rem_next) : rem_next;
      end else begin
         final_val = neg_q ? (32'd0 - quo_next) : quo_next;
      end
   end

   // Control FSM and datapath registers; outputs are all registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= 5'd0;
         op_rem   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dvd      <= 32'd0;
         dsr      <= 32'd0;
         rem      <= 32'd0;
         quo      <= 32'd0;
         result_q <= 32'd0;
         ready_q  <= 1'b0;
         waddr_q  <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               ready_q <= 1'b0;
               if (start_ok) begin
                  waddr_q <= bus.reg_waddr_i;
                  if (bus.divisor_i == 32'd0) begin
                     result_q <= bus.op_i[1] ? bus.dividend_i : 32'hFFFF_FFFF;
                     ready_q  <= 1'b1;
                     state    <= END;
                  end else begin
                     op_rem <= bus.op_i[1];
                     neg_q  <= a_neg ^ b_neg;
                     neg_r  <= a_neg;
                     dvd    <= a_mag;
                     dsr    <= b_mag;
                     rem    <= 32'd0;
                     quo    <= 32'd0;
                     count  <= 5'd0;
                     state  <= CALC;
                  end
               end
            end
            CALC: begin
               if (bus.flush_i) begin
                  count <= 5'd0;
                  state <= IDLE;
               end else begin
                  rem   <= rem_next;
                  quo   <= quo_next;
                  dvd   <= {dvd[30:0], 1'b0};
                  count <= count + 5'd1;
                  if (count == 5'd31) begin
                     result_q <= final_val;
                     ready_q  <= 1'b1;
                     state    <= END;
                  end
               end
            end
            END: begin
               ready_q <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the RV32M divider: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_div;

   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] last_result = 32'd0;

   div_if bus();

   div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running core clock
   always #5 clk = ~clk;

   // Reference: RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint ua;
      longint ub;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (op[1:0])
         2'b00:   return 32'(sa / sb);
         2'b01:   return 32'(ua / ub);
         2'b10:   return 32'(sa % sb);
         default: return 32'(ua % ub);
      endcase
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.start_i     = 1'b0;
      bus.op_i        = 3'b000;
      bus.dividend_i  = 32'd0;
      bus.divisor_i   = 32'd0;
      bus.reg_waddr_i = 5'd0;
      bus.flush_i     = 1'b0;
   endtask

   // Called at a falling edge; returns at the falling edge after the start edge
   task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      bus.start_i     = 1'b1;
      bus.op_i        = op;
      bus.dividend_i  = a;
      bus.divisor_i   = b;
      bus.reg_waddr_i = rd;
      @(posedge clk);
      @(negedge clk);
      drive_idle();
   endtask

   // Issue one operation and check latency, result, rd and busy/ready shape
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      int lat;
      logic [31:0] exp;
      exp = model(op, a, b);
      apply_stimulus(op, a, b, rd);
      check_output({tag, "_busy_start"}, 32'(bus.div_busy_o), 32'd1);
      lat = 0;
      while (bus.ready_o !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_output({tag, "_latency"}, 32'(lat), (b == 32'd0) ? 32'd0 : 32'd32);
      check_output({tag, "_result"}, bus.result_o, exp);
      check_output({tag, "_rd"}, 32'(bus.reg_waddr_o), 32'(rd));
      check_output({tag, "_busy_end"}, 32'(bus.div_busy_o), 32'd1);
      @(negedge clk);
      check_output({tag, "_ready_drop"}, 32'(bus.ready_o), 32'd0);
      check_output({tag, "_idle"}, 32'(bus.div_busy_o), 32'd0);
      last_result = exp;
   endtask

   // Directed and random sequence
   initial begin
      int pulses;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  sel;
      int mode;

      drive_idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_output("reset_result", bus.result_o, 32'd0);
      check_output("reset_ready", 32'(bus.ready_o), 32'd0);
      check_output("reset_rd", 32'(bus.reg_waddr_o), 32'd0);
      check_output("reset_busy", 32'(bus.div_busy_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd9);
      run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd10);
      check_output("remu_100_7_value", last_result, 32'd2);
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1);
      run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2);
      run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd3);
      run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd4);
      run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 5'd5);
      run_op("rem_by0", OP_REM, 32'h8000_0001, 32'd0, 5'd6);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
      run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);

      // Flush ten cycles into CALC: no ready, result held
      apply_stimulus(OP_DIVU, 32'd1000, 32'd7, 5'd11);
      repeat (10) @(negedge clk);
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      check_output("flush_busy", 32'(bus.div_busy_o), 32'd0);
      check_output("flush_ready", 32'(bus.ready_o), 32'd0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.ready_o === 1'b1) pulses++;
      end
      check_output("flush_no_pulse", 32'(pulses), 32'd0);
      check_output("flush_result_held", bus.result_o, last_result);
      run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd12);

      // Flush together with start in IDLE: nothing starts
      bus.start_i    = 1'b1;
      bus.flush_i    = 1'b1;
      bus.op_i       = OP_DIVU;
      bus.dividend_i = 32'd50;
      bus.divisor_i  = 32'd5;
      @(negedge clk);
      drive_idle();
      check_output("flush_start_busy", 32'(bus.div_busy_o), 32'd0);
      repeat (2) @(negedge clk);
      check_output("flush_start_ready", 32'(bus.ready_o), 32'd0);

      // Second start mid-CALC must be ignored
      apply_stimulus(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd13);
      repeat (5) @(negedge clk);
      bus.start_i     = 1'b1;
      bus.op_i        = OP_REMU;
      bus.dividend_i  = 32'd77;
      bus.divisor_i   = 32'd10;
      bus.reg_waddr_i = 5'd20;
      @(negedge clk);
      drive_idle();
      pulses = 6;
      while (bus.ready_o !== 1'b1 && pulses < 40) begin
         @(negedge clk);
         pulses++;
      end
      check_output("busy_start_latency", 32'(pulses), 32'd32);
      check_output("busy_start_result", bus.result_o, model(OP_DIV, 32'hFFFF_FF9C, 32'd7));
      check_output("busy_start_rd", 32'(bus.reg_waddr_o), 32'd13);
      repeat (3) @(negedge clk);
      check_output("busy_start_no_second", 32'(bus.div_busy_o), 32'd0);

      // Asynchronous reset mid-CALC
      apply_stimulus(OP_DIVU, 32'd12345, 32'd11, 5'd14);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("rst_mid_result", bus.result_o, 32'd0);
      check_output("rst_mid_ready", 32'(bus.ready_o), 32'd0);
      check_output("rst_mid_rd", 32'(bus.reg_waddr_o), 32'd0);
      check_output("rst_mid_busy", 32'(bus.div_busy_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.ready_o === 1'b1) pulses++;
      end
      check_output("rst_no_ready", 32'(pulses), 32'd0);

      // Randomized operations, including zero/minus-one/minimum operands
      for (int i = 0; i < 24; i++) begin
         sel  = 2'($urandom_range(0, 3));
         op   = {1'b1, sel};
         a    = $urandom;
         mode = $urandom_range(0, 7);
         if (mode == 0) b = 32'd0;
         else if (mode == 1) b = 32'hFFFF_FFFF;
         else if (mode == 2) b = 32'($urandom_range(1, 15));
         else b = $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, 5'($urandom_range(0, 31)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
